// File: rtl/compress_pkg.sv
// Shared definitions for the codebook compressor: FSM state encoding and default bus widths.
package compress_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_IDX_W  = 8;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SEARCH = 2'b01;
    localparam logic [1:0] ST_WRITE  = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SEARCH = ST_SEARCH,
        S_WRITE  = ST_WRITE,
        S_DONE   = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/search_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the search datapath.
// Counts while enabled, saturates at TIMEOUT, and returns to zero on clear.
module search_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == LIMIT);

endmodule

// File: rtl/compress_seq_ctrl.sv
// Top-level sequencer: walks every image block, launches a codebook search for each,
// and writes the winning index to RAM2 at BASE_ADDR + block. All outputs are registered.
module compress_seq_ctrl
    import compress_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                IDX_W      = DEF_IDX_W,
    parameter int                NUM_BLOCKS = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              search_start,
    output logic [ADDR_W-1:0] search_block,
    input  logic              search_done,
    input  logic [IDX_W-1:0]  search_index,
    output logic              ram2_we,
    output logic [ADDR_W-1:0] ram2_a,
    output logic [IDX_W-1:0]  ram2_d,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);

    // Datapath handshake: search_start is a one-cycle request for search_block; the
    // datapath answers with a one-cycle search_done carrying search_index. A response is
    // accepted only while in SEARCH; anything arriving in another state is dropped.

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] ram2_a_q, ram2_a_d;
    logic              err_q, err_d;
    logic              sstart_q, sstart_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              wd_expire;

    search_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != S_SEARCH),
        .enable (state_q == S_SEARCH),
        .expire (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ram2_a_d = ram2_a_q;
        sstart_d = 1'b0;
        we_d     = 1'b0;
        done_d   = 1'b0;
        if (abort) begin
            // Overrides every transition: counter, index and err stay as they are.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_SEARCH;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        sstart_d = 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (search_done) begin
                        state_d  = S_WRITE;
                        idx_d    = search_index;
                        ram2_a_d = BASE_ADDR + cnt_q;
                        we_d     = 1'b1;
                    end else if (wd_expire) begin
                        state_d  = S_WRITE;
                        idx_d    = {IDX_W{1'b1}};
                        err_d    = 1'b1;
                        ram2_a_d = BASE_ADDR + cnt_q;
                        we_d     = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == LAST_BLK) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_SEARCH;
                        cnt_d    = cnt_q + 1'b1;
                        sstart_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_SEARCH) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            ram2_a_q <= '0;
            err_q    <= 1'b0;
            sstart_q <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ram2_a_q <= ram2_a_d;
            err_q    <= err_d;
            sstart_q <= sstart_d;
            we_q     <= we_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign state        = state_q;
    assign search_start = sstart_q;
    assign search_block = cnt_q;
    assign ram2_we      = we_q;
    assign ram2_a       = ram2_a_q;
    assign ram2_d       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_compress_seq_ctrl.sv
// Bench for compress_seq_ctrl: a 4-block instance with a short watchdog and a 1-block
// instance at the top of the address space, checked against a per-block timing model.
module tb_compress_seq_ctrl;

    localparam int NB = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        search_done = 1'b0;
    logic [7:0]  search_index = 8'h00;
    logic        search_start;
    logic [19:0] search_block;
    logic        ram2_we;
    logic [19:0] ram2_a;
    logic [7:0]  ram2_d;
    logic [1:0]  state;
    logic        busy, done, err;

    logic        b_start = 1'b0;
    logic        b_abort = 1'b0;
    logic        b_search_done = 1'b0;
    logic [7:0]  b_search_index = 8'h00;
    logic        b_search_start;
    logic [19:0] b_search_block;
    logic        b_ram2_we;
    logic [19:0] b_ram2_a;
    logic [7:0]  b_ram2_d;
    logic [1:0]  b_state;
    logic        b_busy, b_done, b_err;

    int          total = 0;
    int          bad = 0;
    bit          model_err = 1'b0;
    logic [27:0] exp_q[$];

    compress_seq_ctrl #(
        .ADDR_W(20), .IDX_W(8), .NUM_BLOCKS(NB), .BASE_ADDR(20'h00000), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .search_start(search_start), .search_block(search_block),
        .search_done(search_done), .search_index(search_index),
        .ram2_we(ram2_we), .ram2_a(ram2_a), .ram2_d(ram2_d),
        .state(state), .busy(busy), .done(done), .err(err)
    );

    compress_seq_ctrl #(
        .ADDR_W(20), .IDX_W(8), .NUM_BLOCKS(1), .BASE_ADDR(20'hFFFFF), .TIMEOUT(TO)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .search_start(b_search_start), .search_block(b_search_block),
        .search_done(b_search_done), .search_index(b_search_index),
        .ram2_we(b_ram2_we), .ram2_a(b_ram2_a), .ram2_d(b_ram2_d),
        .state(b_state), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM2 write must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (!rst && ram2_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL extra_write: observed a=%0h d=%0h expected no write", ram2_a, ram2_d);
            end else begin
                logic [27:0] w;
                w = exp_q.pop_front();
                assert ({ram2_a, ram2_d} === w) else begin
                    bad++;
                    $error("FAIL write_data: observed a=%0h d=%0h expected a=%0h d=%0h",
                           ram2_a, ram2_d, w[27:8], w[7:0]);
                end
            end
        end
    end

    task automatic start_image();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_err = 1'b0;
        check("start_state", state, 2'b01);
        check("start_err_clear", err, 1'b0);
    endtask

    // Serve one block: the response comes lat cycles after search_start (never if lat>TO).
    task automatic run_block(input int blk, input int lat, input logic [7:0] idx,
                             input bit noise, input bit last);
        int wc;
        int waited;
        wc = (lat <= TO) ? lat + 1 : TO + 1;
        exp_q.push_back({20'(blk), (lat <= TO) ? idx : 8'hFF});
        if (lat > TO) model_err = 1'b1;
        waited = 0;
        while (search_start !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("search_start_seen", search_start, 1'b1);
        check("search_block", search_block, blk);
        for (int c = 0; c <= wc; c++) begin
            if (c == wc) begin
                check("write_we", ram2_we, 1'b1);
                check("write_state", state, 2'b10);
                check("write_busy", busy, 1'b1);
                check("write_err", err, model_err);
            end else begin
                check("search_state", state, 2'b01);
                check("search_we_low", ram2_we, 1'b0);
            end
            search_done  = (c == lat && lat <= TO) || (noise && c == wc);
            search_index = (c == lat) ? idx : 8'($urandom);
            start        = noise && (c == 1) && (wc > 1);
            tick();
        end
        search_done = 1'b0;
        start       = 1'b0;
        if (last) begin
            check("done_pulse", done, 1'b1);
            check("done_state", state, 2'b11);
        end else begin
            check("next_search_start", search_start, 1'b1);
            check("next_state", state, 2'b01);
        end
    endtask

    task automatic finish_image();
        tick();
        check("idle_state", state, 2'b00);
        check("idle_done_low", done, 1'b0);
        check("idle_busy_low", busy, 1'b0);
        check("idle_err", err, model_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 2'b00);
        check({tag, "_sstart"}, search_start, 1'b0);
        check({tag, "_sblock"}, search_block, 20'h0);
        check({tag, "_we"}, ram2_we, 1'b0);
        check({tag, "_a"}, ram2_a, 20'h0);
        check({tag, "_d"}, ram2_d, 8'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int lat;
        logic [7:0] idx;

        // Reset values
        tick();
        tick();
        check_reset_values("reset");
        check("b_reset_state", b_state, 2'b00);
        rst = 1'b0;
        tick();

        // Four blocks, response three cycles after each search_start
        start_image();
        for (int b = 0; b < NB; b++) run_block(b, 3, 8'($urandom), 1'b0, b == NB - 1);
        finish_image();

        // search_done in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            search_done  = 1'b1;
            search_index = 8'($urandom);
            tick();
            check("idle_ignore_state", state, 2'b00);
        end
        search_done = 1'b0;

        // Watchdog expiry on block 0, err sticky through DONE
        start_image();
        run_block(0, 100, 8'h00, 1'b0, 1'b0);
        for (int b = 1; b < NB; b++) run_block(b, $urandom_range(0, 5), 8'($urandom), 1'b0, b == NB - 1);
        finish_image();
        tick();
        check("err_sticky_idle", err, 1'b1);

        // Boundaries: response on the expiry cycle wins; one cycle later times out
        start_image();
        run_block(0, TO, 8'($urandom), 1'b1, 1'b0);
        run_block(1, TO + 1, 8'($urandom), 1'b1, 1'b0);
        run_block(2, 0, 8'($urandom), 1'b1, 1'b0);
        run_block(3, $urandom_range(0, 20), 8'($urandom), 1'b1, 1'b1);
        finish_image();

        // Randomized images with stray start/search_done pulses
        for (int img = 0; img < 4; img++) begin
            start_image();
            for (int b = 0; b < NB; b++) begin
                lat = $urandom_range(0, 18);
                idx = 8'($urandom);
                run_block(b, lat, idx, 1'($urandom_range(0, 1)), b == NB - 1);
            end
            finish_image();
        end

        // Abort on the cycle block 2 would be written
        start_image();
        run_block(0, $urandom_range(0, 5), 8'($urandom), 1'b0, 1'b0);
        run_block(1, $urandom_range(0, 5), 8'($urandom), 1'b0, 1'b0);
        tick();
        tick();
        search_done  = 1'b1;
        search_index = 8'($urandom);
        abort        = 1'b1;
        tick();
        search_done = 1'b0;
        abort       = 1'b0;
        check("abort_we_low", ram2_we, 1'b0);
        check("abort_state", state, 2'b00);
        check("abort_sstart_low", search_start, 1'b0);
        check("abort_done_low", done, 1'b0);
        check("abort_counter_kept", search_block, 20'd2);
        check("abort_err_kept", err, model_err);
        for (int i = 0; i < 5; i++) tick();
        check("abort_stays_idle", state, 2'b00);

        // Asynchronous reset mid-SEARCH after a timed-out block
        start_image();
        run_block(0, 100, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_reset_err", err, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_queue_empty", exp_q.size(), 0);
        start_image();
        for (int b = 0; b < NB; b++) run_block(b, 1, 8'($urandom), 1'b0, b == NB - 1);
        finish_image();

        // Single-block instance at the top of the address space
        idx = 8'($urandom);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_search_start", b_search_start, 1'b1);
        check("b_search_block", b_search_block, 20'h0);
        tick();
        tick();
        b_search_done  = 1'b1;
        b_search_index = idx;
        tick();
        b_search_done = 1'b0;
        check("b_we", b_ram2_we, 1'b1);
        check("b_addr", b_ram2_a, 20'hFFFFF);
        check("b_data", b_ram2_d, idx);
        tick();
        check("b_done", b_done, 1'b1);
        check("b_done_state", b_state, 2'b11);
        check("b_we_low", b_ram2_we, 1'b0);
        tick();
        check("b_idle", b_state, 2'b00);
        check("b_err", b_err, 1'b0);

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
